// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the column-serial multiply load sequencer.
// Contents: FSM state enum, per-column height/start-index functions and the
// counter width helper. Functions take the operand width explicitly so the
// package stays independent of any instance parameters.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSettle,
    StDone
  } state_e;

  // Column k of an n x n product holds h(k) = min(k+1, 2n-1-k) partial products.
  function automatic int col_height(input int k, input int n);
    return (k + 1 < 2 * n - 1 - k) ? k + 1 : 2 * n - 1 - k;
  endfunction

  // Lowest multiplicand index j contributing to column k.
  function automatic int col_lo(input int k, input int n);
    return (k - n + 1 > 0) ? k - n + 1 : 0;
  endfunction

  // One counter serves both the load index and the settle wait.
  function automatic int cnt_width(input int n, input int comp_lat);
    return $clog2(n + comp_lat + 1);
  endfunction

endpackage

// File: rtl/mul_load_sequencer_pp_col_gen.sv
// pp_col_gen: combinational partial-product bit generator.
// For load index i it emits one bit per product column so that, after N shifts,
// each column shift register of depth h(k) holds exactly that column's bits.
// Columns shorter than N receive leading zeros which fall out of the register.
// Ports:
//   i_a, i_b   registered operands (N bits each)
//   i_idx      load index i, 0..N-1
//   o_col_bit  serial bit per column (2N-1 bits)
module pp_col_gen
  import mul_seq_pkg::*;
#(
  parameter int unsigned N  = 28,
  parameter int unsigned CW = 5
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  input  logic [CW-1:0]  i_idx,
  output logic [2*N-2:0] o_col_bit
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  for (genvar k = 0; k < 2 * int'(N) - 1; k++) begin : g_col
    localparam int HK = col_height(k, int'(N));
    localparam int LO = col_lo(k, int'(N));
    // First load cycle that carries a real partial product for this column.
    localparam int SK = int'(N) - HK;

    logic          w_act;
    logic [IW-1:0] w_ja;
    logic [IW-1:0] w_jb;

    assign w_act = (int'(i_idx) >= SK) && (int'(i_idx) < int'(N));
    assign w_ja  = IW'(LO + int'(i_idx) - SK);
    assign w_jb  = IW'(k - LO - int'(i_idx) + SK);
    // Indices are only meaningful while w_act; the AND masks everything else.
    assign o_col_bit[k] = w_act & i_a[w_ja] & i_b[w_jb];
  end

endmodule

// File: rtl/mul_load_sequencer.sv
// mul_load_sequencer: sequences one unsigned N x N multiply through the
// column-serial shift-register/compressor datapath.
//   IDLE   -> accept operands over in_valid/in_ready
//   LOAD   -> N cycles of col_shift, one partial-product bit per column per cycle
//   SETTLE -> COMP_LAT+1 cycles; last cycle captures res_in[2N-1:0]
//   DONE   -> present out_prod/out_valid; may accept the next pair directly
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake; in_a, in_b unsigned operands
//   col_bit, col_shift   column shift-register inputs and shift enable
//   res_in               compressor result dst0..dst(2N); bit 2N unused
//   out_prod/out_valid/out_ready  product handshake
//   busy                 high in every state except IDLE
// Optional: define MUL_LOAD_SEQUENCER_SELF_CHECK_EN to add output chk_err, a
// sticky flag set when the captured result differs from a*b or res_in[2N]=1.
module mul_load_sequencer
  import mul_seq_pkg::*;
#(
  parameter int unsigned N        = 28,
  parameter int unsigned COMP_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic [2*N-2:0] col_bit,
  output logic           col_shift,
  input  logic [2*N:0]   res_in,
  output logic [2*N-1:0] out_prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
`ifdef MUL_LOAD_SEQUENCER_SELF_CHECK_EN
  ,
  output logic           chk_err
`endif
);

  localparam int unsigned CW = cnt_width(int'(N), int'(COMP_LAT));

  state_e         r_state, w_state_d;
  logic [CW-1:0]  r_cnt, w_cnt_d;
  logic [N-1:0]   r_a, r_b;
  logic [2*N-1:0] r_prod;
  logic           w_load;
  logic           w_capture;
  logic [2*N-2:0] w_pp;

  pp_col_gen #(
    .N  (N),
    .CW (CW)
  ) u_pp_col_gen (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_idx     (r_cnt),
    .o_col_bit (w_pp)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_load    = 1'b0;
    w_capture = 1'b0;
    in_ready  = 1'b0;
    col_shift = 1'b0;
    col_bit   = '0;
    out_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load    = 1'b1;
          w_cnt_d   = '0;
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        col_shift = 1'b1;
        col_bit   = w_pp;
        if (r_cnt == CW'(N - 1)) begin
          w_cnt_d   = '0;
          w_state_d = StSettle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StSettle: begin
        if (r_cnt == CW'(COMP_LAT)) begin
          w_capture = 1'b1;
          w_cnt_d   = '0;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            // Chain straight into the next load without an idle cycle.
            w_load    = 1'b1;
            w_cnt_d   = '0;
            w_state_d = StLoad;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign busy     = (r_state != StIdle);
  assign out_prod = r_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_prod  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_load) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      if (w_capture) begin
        r_prod <= res_in[2*N-1:0];
      end
    end
  end

`ifdef MUL_LOAD_SEQUENCER_SELF_CHECK_EN
  logic [2*N-1:0] w_ref;
  logic           r_chk_err;

  assign w_ref   = (2 * N)'(r_a) * (2 * N)'(r_b);
  assign chk_err = r_chk_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_err <= 1'b0;
    end else if (w_capture && ((res_in[2*N-1:0] != w_ref) || res_in[2*N])) begin
      r_chk_err <= 1'b1;
    end
  end
`else
  // Top result bit is only inspected by the self-check.
  logic w_unused_res_msb;
  assign w_unused_res_msb = res_in[2*N];
`endif

endmodule

// File: tb/tb_mul_load_sequencer.sv
module tb_mul_load_sequencer;

  localparam int N        = 28;
  localparam int COMP_LAT = 0;
  localparam int W        = 2 * N - 1;
  localparam int LAT      = N + COMP_LAT + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic [W-1:0]   col_bit;
  logic           col_shift;
  logic [2*N:0]   res_in;
  logic [2*N-1:0] out_prod;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
`ifdef MUL_LOAD_SEQUENCER_SELF_CHECK_EN
  logic           chk_err;
`endif

  int errors = 0;
  int checks = 0;

  logic         flip5 = 1'b0;
  logic [W-1:0] trace [N];
  int           nshift;

  always #5 clk = ~clk;

  mul_load_sequencer #(
    .N        (N),
    .COMP_LAT (COMP_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .col_bit   (col_bit),
    .col_shift (col_shift),
    .res_in    (res_in),
    .out_prod  (out_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef MUL_LOAD_SEQUENCER_SELF_CHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  // Behavioural shift-register + compressor: each column keeps its newest
  // h(k) bits; the result is the weighted sum of ones over all columns.
  logic [N-1:0]   m_col [W];
  logic [2*N:0]   res_model;

  function automatic int hgt(input int k);
    return (k + 1 < W - k) ? k + 1 : W - k;
  endfunction

  always @(posedge clk) begin
    if (col_shift) begin
      for (int k = 0; k < W; k++) m_col[k] <= {m_col[k][N-2:0], col_bit[k]};
    end
  end

  always_comb begin
    longint unsigned sum;
    logic [N-1:0]    mask;
    sum  = 0;
    mask = '0;
    for (int k = 0; k < W; k++) begin
      mask = {N{1'b1}} >> (N - hgt(k));
      sum  = sum + (longint'($countones(m_col[k] & mask)) << k);
    end
    res_model = sum[2*N:0];
  end

  assign res_in = {res_model[2*N:6], res_model[5] ^ flip5, res_model[4:0]};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one pair, accept it, then run until out_valid (bounded).
  // lat counts edges from the accept edge; trace holds col_bit per shift.
  task automatic do_txn(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
    int g;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    tick();
    in_valid = 1'b0;
    in_a = N'($urandom);
    in_b = N'($urandom);
    lat = 0;
    nshift = 0;
    while (!out_valid && lat < 4 * LAT) begin
      if (col_shift) begin
        if (nshift < N) trace[nshift] = col_bit;
        nshift++;
      end
      tick();
      lat++;
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_prod !== '0) begin errors++; $display("FAIL reset_out_prod got=%h exp=0", out_prod); end
    checks++; if (col_shift !== 1'b0) begin errors++; $display("FAIL reset_col_shift got=%b exp=0", col_shift); end
    checks++; if (col_bit !== '0) begin errors++; $display("FAIL reset_col_bit got=%h exp=0", col_bit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_one_by_one;
    int lat;
    int bad;
    logic [W-1:0] e;
    do_txn(N'(1), N'(1), lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL one_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (out_prod !== 56'd1) begin errors++; $display("FAIL one_prod got=%h exp=1", out_prod); end
    checks++; if (nshift != N) begin errors++; $display("FAIL one_shifts got=%0d exp=%0d", nshift, N); end
    bad = 0;
    for (int i = 0; i < N; i++) begin
      e = (i == N - 1) ? W'(1) : '0;
      if (trace[i] !== e) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL one_col_trace bad_cycles=%0d exp=0", bad); end
    drain();
  endtask

  task automatic test_all_ones;
    int lat;
    int ones27;
    int bad54;
    do_txn({N{1'b1}}, {N{1'b1}}, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL ones_latency got=%0d exp=%0d", lat, LAT); end
    checks++;
    if (out_prod !== 56'h00FFFFFFE0000001) begin
      errors++; $display("FAIL ones_prod got=%h exp=00ffffffe0000001", out_prod);
    end
    ones27 = 0;
    bad54 = 0;
    for (int i = 0; i < N; i++) begin
      if (trace[i][27] === 1'b1) ones27++;
      if (trace[i][W-1] !== ((i == N - 1) ? 1'b1 : 1'b0)) bad54++;
    end
    checks++; if (ones27 != N) begin errors++; $display("FAIL ones_col27 got=%0d exp=%0d", ones27, N); end
    checks++; if (bad54 != 0) begin errors++; $display("FAIL ones_col54 bad_cycles=%0d exp=0", bad54); end
    drain();
  endtask

  task automatic test_random;
    int lat;
    logic [N-1:0] a, b;
    logic [2*N-1:0] e;
    for (int t = 0; t < 6; t++) begin
      a = N'($urandom);
      b = N'($urandom);
      e = (2 * N)'(a) * (2 * N)'(b);
      do_txn(a, b, lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL rand_latency got=%0d exp=%0d", lat, LAT); end
      checks++;
      if (out_prod !== e) begin
        errors++; $display("FAIL rand_prod a=%h b=%h got=%h exp=%h", a, b, out_prod, e);
      end
      drain();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    do_txn(N'(3), N'(5), lat);
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
      checks++; if (out_prod !== 56'd15) begin errors++; $display("FAIL bp_prod got=%h exp=f", out_prod); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = N'(11);
    in_b = N'(13);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++; if (col_shift !== 1'b1) begin errors++; $display("FAIL bp_next_load got=%b exp=1", col_shift); end
    lat = 0;
    while (!out_valid && lat < 4 * LAT) begin
      tick();
      lat++;
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL bp_chain_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (out_prod !== 56'd143) begin errors++; $display("FAIL bp_chain_prod got=%h exp=8f", out_prod); end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [2*N-1:0] q [$];
    int acc_cyc [$];
    int cyc, n_acc, n_out, gaps, bad_int;
    logic acc;
    logic [2*N-1:0] e;
    cyc = 0; n_acc = 0; n_out = 0; gaps = 0;
    in_a = N'($urandom);
    in_b = N'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (n_out < 8 && cyc < 8 * (LAT + 1) + 100) begin
      if (cyc > 0 && !busy) gaps++;
      if (out_valid) begin
        e = (q.size() > 0) ? q.pop_front() : '1;
        checks++;
        if (out_prod !== e) begin errors++; $display("FAIL b2b_prod got=%h exp=%h", out_prod, e); end
        n_out++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back((2 * N)'(in_a) * (2 * N)'(in_b));
        acc_cyc.push_back(cyc);
        n_acc++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (n_acc < 8) begin
          in_a = N'($urandom);
          in_b = N'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++; if (n_out != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", n_out); end
    // One DONE cycle separates products, so accepts land LAT+1 edges apart.
    bad_int = (acc_cyc.size() == 8) ? 0 : 1;
    for (int i = 1; i < acc_cyc.size(); i++) begin
      if (acc_cyc[i] - acc_cyc[i-1] != LAT + 1) bad_int++;
    end
    checks++; if (bad_int != 0) begin errors++; $display("FAIL b2b_interval bad=%0d exp=0", bad_int); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_idle_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_reset_mid_load;
    int lat;
    in_a = N'($urandom);
    in_b = N'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (13) tick();
    checks++; if (col_shift !== 1'b1) begin errors++; $display("FAIL mid_in_load got=%b exp=1", col_shift); end
    rst = 1'b1;
    #1;
    checks++; if (col_shift !== 1'b0) begin errors++; $display("FAIL mid_col_shift got=%b exp=0", col_shift); end
    checks++; if (col_bit !== '0) begin errors++; $display("FAIL mid_col_bit got=%h exp=0", col_bit); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    do_txn(N'(7), N'(9), lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL mid_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (out_prod !== 56'd63) begin errors++; $display("FAIL mid_prod got=%h exp=3f", out_prod); end
    drain();
  endtask

`ifdef MUL_LOAD_SEQUENCER_SELF_CHECK_EN
  task automatic test_self_check;
    int lat;
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL chk_clean got=%b exp=0", chk_err); end
    flip5 = 1'b1;
    do_txn(N'($urandom), N'($urandom), lat);
    flip5 = 1'b0;
    checks++; if (chk_err !== 1'b1) begin errors++; $display("FAIL chk_set got=%b exp=1", chk_err); end
    drain();
    do_txn(N'(3), N'(3), lat);
    checks++; if (chk_err !== 1'b1) begin errors++; $display("FAIL chk_sticky got=%b exp=1", chk_err); end
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL chk_reset got=%b exp=0", chk_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_one_by_one();
    test_all_ones();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_load();
`ifdef MUL_LOAD_SEQUENCER_SELF_CHECK_EN
    test_self_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
